me_search_engine: RTL and testbench
===================================

Name: me_search_engine

Overview:
Parametrised full-search block-matching motion estimator, next generation of the per-block SAE search unit. It holds one BLK x BLK current block and evaluates every candidate displacement in a (BLK+2*RANGE)-square search window. The window is read row by row through a synchronous memory port. Outputs are the signed motion vector and the minimum SAD, with optional early-termination mode. It sits between the frame-buffer window fetcher and the MV/encoder stage.

Parameters:
PIX_W, 8, pixel width in bits
BLK, 16, block edge in pixels (power of 2, >=2)
RANGE, 16, max displacement; candidates per axis NP = 2*RANGE+1
SAD_W, PIX_W+$clog2(BLK*BLK), SAD width; guaranteed no overflow
MV_W, $clog2(RANGE+1)+1, signed MV component width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
cur_valid  in  1  current-block row beat valid
cur_ready  out  1  = !busy; beat accepted when cur_valid & cur_ready
cur_row  in  BLK*PIX_W  one block row, pixel 0 in LSBs
start  in  1  begin search; sampled only in IDLE
early_term_en  in  1  sampled with start; enables candidate abort
win_rd_en  out  1  window read strobe
win_rd_row  out  $clog2(BLK+2*RANGE)  window row address
win_rd_col  out  $clog2(BLK+2*RANGE)  window column of pixel 0
win_rd_data  in  BLK*PIX_W  BLK pixels from (row,col), valid 1 cycle after win_rd_en
busy  out  1  search in progress
done  out  1  one-cycle pulse, results valid
mv_x  out  MV_W  signed, dx-RANGE
mv_y  out  MV_W  signed, dy-RANGE
best_sad  out  SAD_W  minimum SAD

Behaviour:
- Reset: busy=0, done=0, mv_x=mv_y=0, best_sad=0, win_rd_en=0. FSM goes to IDLE; cur-row write pointer=0. Stored current block is cleared to 0. Reset mid-search aborts immediately; no done pulse is issued.
- Current load: accepted beats write rows 0..BLK-1 in order. The pointer wraps to 0 after BLK beats. Loading is allowed only in IDLE. start uses whatever contents are stored.
- FSM: IDLE -> SEARCH on start; SEARCH -> FLUSH after the last read; FLUSH -> DONE when the final candidate is resolved; DONE -> IDLE after 1 cycle, with done=1 in that cycle. start while busy is ignored. start and cur_valid in the same IDLE cycle: the beat is accepted, then the search starts.
- Scan order: dy outer 0..NP-1, dx inner 0..NP-1. For each candidate, rows r=0..BLK-1 are read at (dy+r, dx), one read per cycle, back to back across candidates.
- Row SAD: sum over BLK pixels of |cur[r][i]-win[i]|, unsigned, combinational. Partial accumulator register adds one row SAD per returned beat.
- Candidate complete (row BLK-1 accumulated): if total < best_reg (strict), update best_reg and best dx/dy. Ties keep the earlier raster candidate. best_reg is initialised to all-ones at start.
- Timing, full mode: start sampled in cycle 0; reads in cycles 1..NP*NP*BLK; done in cycle NP*NP*BLK+2.
- Early termination (early_term_en=1): at the edge accumulating row k<BLK-1, abort the candidate if (acc+row_sad) >= best_reg.
  - The beat arriving in the next cycle is discarded, via a 1-deep valid/tag pipe on reads.
  - The address issued in that next cycle is row 0 of the next candidate.
  - Aborting the last candidate proceeds to DONE.
  - Results must equal full-mode results bit-exactly.
- On done: mv_x/mv_y/best_sad load from the best registers and hold until the next done.

Decomposition:
- Package me_pkg: PIX_W default and SAD_W/MV_W width functions; FSM state enum {IDLE, SEARCH, FLUSH, DONE}; mv component typedef.
- Sub-module sad_row_unit: BLK parallel absolute differences plus a balanced adder tree, combinational, parametrised by BLK/PIX_W. Instantiated once.

Test Plan:
1. BLK=4, RANGE=2, window 8x8 random, current block copied at window (row 3, col 1), early_term_en=0 -> mv_x=-1, mv_y=+1, best_sad=0, done exactly 102 cycles after start.
2. Window and current block all 0x37 -> every SAD=0; tie-break -> mv_x=-2, mv_y=-2, best_sad=0.
3. Current all 0xFF, window all 0x00 -> best_sad=4080, mv=(-2,-2); no overflow.
4. Scenario 1 with early_term_en=1 -> identical mv/best_sad; done strictly earlier than cycle 102; no win_rd_en after the last candidate resolves.
5. Reset asserted 40 cycles into a search -> next cycle busy=0, win_rd_en=0, no done pulse. Reload and start again -> scenario 1 result.
6. start pulsed while busy, and cur_valid while busy (cur_ready=0) -> both ignored; results unchanged from the original search.

Source files
------------

// File: rtl/me_pkg.sv
// Shared types and width helpers for the block-matching motion estimator.
// Imported by the SAD row unit and the search engine top.
package me_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int BLK_DEF   = 16;
  localparam int RANGE_DEF = 16;

  function automatic int sad_w(input int pix_w, input int blk);
    return pix_w + $clog2(blk * blk);
  endfunction

  function automatic int mv_w(input int rng);
    return $clog2(rng + 1) + 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    FLUSH,
    DONE
  } state_t;

  typedef logic signed [mv_w(RANGE_DEF)-1:0] mv_t;

endpackage

// File: rtl/me_search_engine_sad_row_unit.sv
// One block row of absolute differences reduced by a balanced adder tree.
// Purely combinational; level 0 holds the per-pixel differences.
module sad_row_unit
  import me_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int BLK   = BLK_DEF,
  parameter int OUT_W = PIX_W + $clog2(BLK)
) (
  input  logic [BLK*PIX_W-1:0] cur,
  input  logic [BLK*PIX_W-1:0] win,
  output logic [OUT_W-1:0]     sad
);

  localparam int LV = $clog2(BLK);

  function automatic logic [PIX_W-1:0] absd(
    input logic [PIX_W-1:0] a,
    input logic [PIX_W-1:0] b
  );
    return (a > b) ? (a - b) : (b - a);
  endfunction

  for (genvar l = 0; l <= LV; l++) begin : g_lvl
    logic [OUT_W-1:0] s [BLK>>l];
    for (genvar k = 0; k < (BLK >> l); k++) begin : g_node
      if (l == 0) begin : g_leaf
        assign s[k] = OUT_W'(absd(cur[k*PIX_W +: PIX_W],
                                  win[k*PIX_W +: PIX_W]));
      end else begin : g_add
        assign s[k] = g_lvl[l-1].s[2*k] + g_lvl[l-1].s[2*k+1];
      end
    end
  end

  assign sad = g_lvl[LV].s[0];

endmodule

// File: rtl/me_search_engine.sv
// Full-search block-matching motion estimator with optional early abort.
// Streams window rows through a 1-cycle synchronous read port.
module me_search_engine
  import me_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int BLK   = BLK_DEF,
  parameter int RANGE = RANGE_DEF,
  parameter int SAD_W = sad_w(PIX_W, BLK),
  parameter int MV_W  = mv_w(RANGE)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cur_valid,
  output logic                              cur_ready,
  input  logic [BLK*PIX_W-1:0]              cur_row,
  input  logic                              start,
  input  logic                              early_term_en,
  output logic                              win_rd_en,
  output logic [$clog2(BLK+2*RANGE)-1:0]    win_rd_row,
  output logic [$clog2(BLK+2*RANGE)-1:0]    win_rd_col,
  input  logic [BLK*PIX_W-1:0]              win_rd_data,
  output logic                              busy,
  output logic                              done,
  output logic signed [MV_W-1:0]            mv_x,
  output logic signed [MV_W-1:0]            mv_y,
  output logic [SAD_W-1:0]                  best_sad
);

  localparam int NP    = 2 * RANGE + 1;
  localparam int AW    = $clog2(BLK + 2 * RANGE);
  localparam int CW    = $clog2(NP);
  localparam int RW    = $clog2(BLK);
  localparam int ROW_W = PIX_W + $clog2(BLK);

  state_t state, state_nx;

  logic [RW-1:0]        wr_ptr;
  logic [BLK*PIX_W-1:0] cur_mem [BLK];

  logic [CW-1:0] rd_dx, rd_dy;
  logic [RW-1:0] rd_r;
  logic          et;

  logic          p_valid;
  logic [CW-1:0] p_dx, p_dy;
  logic [RW-1:0] p_r;

  logic [SAD_W-1:0] acc, best;
  logic [CW-1:0]    best_dx, best_dy;

  logic [ROW_W-1:0] row_sad;
  logic [SAD_W-1:0] total, best_nx;
  logic [CW-1:0]    bdx_nx, bdy_nx;
  logic p_last_row, p_last_cand;
  logic complete, abort, improve;
  logic rd_last_row, rd_last_dx, rd_last;

  sad_row_unit #(
    .PIX_W (PIX_W),
    .BLK   (BLK),
    .OUT_W (ROW_W)
  ) u_sad (
    .cur (cur_mem[p_r]),
    .win (win_rd_data),
    .sad (row_sad)
  );

  assign busy       = (state != IDLE);
  assign cur_ready  = !busy;
  assign done       = (state == DONE);
  assign win_rd_en  = (state == SEARCH);
  assign win_rd_row = AW'(rd_dy) + AW'(rd_r);
  assign win_rd_col = AW'(rd_dx);

  // Datapath decisions for the beat returning this cycle
  always_comb begin
    p_last_row  = (p_r == RW'(BLK - 1));
    p_last_cand = (p_dx == CW'(NP - 1)) && (p_dy == CW'(NP - 1));
    total       = (p_r == '0 ? '0 : acc) + SAD_W'(row_sad);
    complete    = p_valid && p_last_row;
    abort       = p_valid && et && !p_last_row && (total >= best);
    improve     = complete && (total < best);
    best_nx     = improve ? total : best;
    bdx_nx      = improve ? p_dx : best_dx;
    bdy_nx      = improve ? p_dy : best_dy;
    rd_last_row = (rd_r == RW'(BLK - 1));
    rd_last_dx  = (rd_dx == CW'(NP - 1));
    rd_last     = rd_last_row && rd_last_dx && (rd_dy == CW'(NP - 1));
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (start) state_nx = SEARCH;
      SEARCH: begin
        if (abort && p_last_cand) state_nx = DONE;
        else if (rd_last)         state_nx = FLUSH;
      end
      FLUSH:  if (complete) state_nx = DONE;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Current-block row store, written in order while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      for (int i = 0; i < BLK; i++) cur_mem[i] <= '0;
    end else if (cur_valid && cur_ready) begin
      cur_mem[wr_ptr] <= cur_row;
      wr_ptr          <= wr_ptr + RW'(1);
    end
  end

  // Read address generator; an abort skips to the next candidate
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_dx <= '0;
      rd_dy <= '0;
      rd_r  <= '0;
      et    <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        rd_dx <= '0;
        rd_dy <= '0;
        rd_r  <= '0;
        et    <= early_term_en;
      end
    end else if (state == SEARCH) begin
      if (abort || rd_last_row) begin
        rd_r <= '0;
        if (rd_last_dx) begin
          rd_dx <= '0;
          rd_dy <= rd_dy + CW'(1);
        end else begin
          rd_dx <= rd_dx + CW'(1);
        end
      end else begin
        rd_r <= rd_r + RW'(1);
      end
    end
  end

  // Valid/tag pipe matching each read to its returning beat
  always_ff @(posedge clk) begin
    if (reset) begin
      p_valid <= 1'b0;
      p_dx    <= '0;
      p_dy    <= '0;
      p_r     <= '0;
    end else begin
      p_valid <= (state == SEARCH) && !abort;
      p_dx    <= rd_dx;
      p_dy    <= rd_dy;
      p_r     <= rd_r;
    end
  end

  // Partial SAD accumulation and running best candidate
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      best    <= '0;
      best_dx <= '0;
      best_dy <= '0;
    end else if (state == IDLE && start) begin
      best <= '1;
    end else if (p_valid) begin
      acc     <= total;
      best    <= best_nx;
      best_dx <= bdx_nx;
      best_dy <= bdy_nx;
    end
  end

  // Result registers, captured on entry to DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      mv_x     <= '0;
      mv_y     <= '0;
      best_sad <= '0;
    end else if (state != DONE && state_nx == DONE) begin
      mv_x     <= MV_W'(bdx_nx) - MV_W'(RANGE);
      mv_y     <= MV_W'(bdy_nx) - MV_W'(RANGE);
      best_sad <= best_nx;
    end
  end

endmodule

// File: tb/tb_me_search_engine.sv
// Directed bench for me_search_engine with BLK=4, RANGE=2 (8x8 window).
// Vector table covers full and early-abort modes; corner cases are inline.
module tb_me_search_engine;

  localparam int PIX_W = 8;
  localparam int BLK   = 4;
  localparam int RANGE = 2;
  localparam int WIN   = 8;
  localparam int SAD_W = 12;
  localparam int MV_W  = 3;

  logic clk = 1'b0;
  logic reset;
  logic cur_valid, cur_ready, start, early_term_en;
  logic win_rd_en, busy, done;
  logic [BLK*PIX_W-1:0] cur_row, win_rd_data;
  logic [2:0] win_rd_row, win_rd_col;
  logic signed [MV_W-1:0] mv_x, mv_y;
  logic [SAD_W-1:0] best_sad;

  logic [7:0] wmem [WIN][WIN];
  logic [7:0] cblk [BLK][BLK];

  int n_chk  = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int done_cnt = 0;

  typedef struct {
    int scen;
    bit et;
    int mvx;
    int mvy;
    int sad;
    int lat;
    bit lat_exact;
    int reads;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  me_search_engine #(
    .PIX_W (PIX_W),
    .BLK   (BLK),
    .RANGE (RANGE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cur_valid     (cur_valid),
    .cur_ready     (cur_ready),
    .cur_row       (cur_row),
    .start         (start),
    .early_term_en (early_term_en),
    .win_rd_en     (win_rd_en),
    .win_rd_row    (win_rd_row),
    .win_rd_col    (win_rd_col),
    .win_rd_data   (win_rd_data),
    .busy          (busy),
    .done          (done),
    .mv_x          (mv_x),
    .mv_y          (mv_y),
    .best_sad      (best_sad)
  );

  // Synchronous window memory model plus read/done counters
  always @(posedge clk) begin
    if (win_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      for (int i = 0; i < BLK; i++) begin
        int c;
        c = int'(win_rd_col) + i;
        if (c < WIN) win_rd_data[i*PIX_W +: PIX_W] <= wmem[win_rd_row][c];
        else         win_rd_data[i*PIX_W +: PIX_W] <= 8'h00;
      end
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic setup(input int scen);
    int unsigned s;
    s = 32'h1234_5678;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++) begin
        s = s * 32'd1664525 + 32'd1013904223;
        case (scen)
          1:       wmem[r][c] = s[31:24];
          2:       wmem[r][c] = 8'h37;
          default: wmem[r][c] = 8'h00;
        endcase
      end
    for (int r = 0; r < BLK; r++)
      for (int c = 0; c < BLK; c++)
        case (scen)
          1:       cblk[r][c] = wmem[3+r][1+c];
          2:       cblk[r][c] = 8'h37;
          default: cblk[r][c] = 8'hFF;
        endcase
  endtask

  task automatic load();
    for (int r = 0; r < BLK; r++) begin
      cur_valid = 1'b1;
      for (int c = 0; c < BLK; c++) cur_row[c*PIX_W +: PIX_W] = cblk[r][c];
      @(posedge clk); #1;
    end
    cur_valid = 1'b0;
  endtask

  task automatic run(input bit et, output int lat, output int reads);
    int r0;
    early_term_en = et;
    start = 1'b1;
    r0 = rd_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    early_term_en = 1'b0;
    lat = 1;
    while (!done && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    reads = rd_cnt - r0;
  endtask

  initial begin
    int lat, reads, dc0;
    vecs[0] = '{1, 1'b0, -1,  1,    0, 102, 1'b1, 100};
    vecs[1] = '{2, 1'b0, -2, -2,    0, 102, 1'b1, 100};
    vecs[2] = '{3, 1'b0, -2, -2, 4080, 102, 1'b1, 100};
    vecs[3] = '{1, 1'b1, -1,  1,    0, 102, 1'b0,  -1};
    vecs[4] = '{2, 1'b1, -2, -2,    0,  53, 1'b1,  52};
    vecs[5] = '{3, 1'b1, -2, -2, 4080, 102, 1'b1, 100};

    reset = 1'b1;
    cur_valid = 1'b0;
    cur_row = '0;
    start = 1'b0;
    early_term_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rd_en", int'(win_rd_en), 0);
    check("rst_mv_x", int'(mv_x), 0);
    check("rst_mv_y", int'(mv_y), 0);
    check("rst_sad", int'(best_sad), 0);
    check("rst_cur_ready", int'(cur_ready), 1);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      setup(vecs[v].scen);
      load();
      run(vecs[v].et, lat, reads);
      check($sformatf("v%0d_timeout", v), int'(lat < 400), 1);
      check($sformatf("v%0d_mv_x", v), int'(mv_x), vecs[v].mvx);
      check($sformatf("v%0d_mv_y", v), int'(mv_y), vecs[v].mvy);
      check($sformatf("v%0d_sad", v), int'(best_sad), vecs[v].sad);
      if (vecs[v].lat_exact)
        check($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      else
        check($sformatf("v%0d_latency_early", v), int'(lat < vecs[v].lat), 1);
      if (vecs[v].reads >= 0)
        check($sformatf("v%0d_reads", v), reads, vecs[v].reads);
      else
        check($sformatf("v%0d_reads_fewer", v), int'(reads < 100), 1);
      check($sformatf("v%0d_rd_en_at_done", v), int'(win_rd_en), 0);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", v), int'(done), 0);
      check($sformatf("v%0d_hold_sad", v), int'(best_sad), vecs[v].sad);
    end

    // Reset 40 cycles into a search aborts it without a done pulse
    setup(1);
    load();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (39) begin
      @(posedge clk); #1;
    end
    check("mid_busy_before_reset", int'(busy), 1);
    dc0 = done_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_rd_en", int'(win_rd_en), 0);
    check("abort_done", int'(done), 0);
    check("abort_mv_x", int'(mv_x), 0);
    check("abort_sad", int'(best_sad), 0);
    check("abort_cur_ready", int'(cur_ready), 1);
    repeat (120) begin
      @(posedge clk); #1;
    end
    check("abort_no_done", done_cnt - dc0, 0);
    load();
    run(1'b0, lat, reads);
    check("rerun_mv_x", int'(mv_x), -1);
    check("rerun_mv_y", int'(mv_y), 1);
    check("rerun_sad", int'(best_sad), 0);
    check("rerun_latency", lat, 102);
    @(posedge clk); #1;

    // start and a current-row beat while busy are both ignored
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 400) begin
      if (lat == 10) begin
        check("busy_cur_ready", int'(cur_ready), 0);
        start = 1'b1;
        cur_valid = 1'b1;
        cur_row = '1;
      end else begin
        start = 1'b0;
        cur_valid = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    cur_valid = 1'b0;
    check("busy_latency", lat, 102);
    check("busy_mv_x", int'(mv_x), -1);
    check("busy_mv_y", int'(mv_y), 1);
    check("busy_sad", int'(best_sad), 0);
    dc0 = done_cnt;
    repeat (110) begin
      @(posedge clk); #1;
    end
    check("busy_no_second_search", done_cnt - dc0, 1);
    check("busy_idle_after", int'(busy), 0);
    run(1'b0, lat, reads);
    check("busy_block_intact_sad", int'(best_sad), 0);
    check("busy_block_intact_mv_x", int'(mv_x), -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
